// File: rtl/ex_div_unit_if.sv
// EX-stage <-> divider handshake bundle: operands and control from EX, registered result back.
interface ex_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) beside the EX stage.
// Result is {remainder, quotient}; iteration runs on operand magnitudes, signs fixed at the end.
module ex_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  ex_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     rem_r;
  logic [WIDTH-1:0]     quo_r;
  logic [WIDTH-1:0]     dvs_r;
  logic                 neg_quo;
  logic                 neg_rem;
  logic [2*WIDTH-1:0]   result_r;
  logic                 ready_r;

  logic [WIDTH-1:0]     op1_mag;
  logic [WIDTH-1:0]     op2_mag;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_nxt;
  logic [WIDTH-1:0]     quo_nxt;

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;

  always_comb begin
    op1_mag = bus.opdata1_i;
    op2_mag = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[WIDTH-1])
      op1_mag = ~bus.opdata1_i + WIDTH'(1);
    if (bus.signed_div_i && bus.opdata2_i[WIDTH-1])
      op2_mag = ~bus.opdata2_i + WIDTH'(1);

    // shifted < 2*divisor, so bit WIDTH of the difference is a clean borrow flag
    shifted = {rem_r, quo_r[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_r};
    if (trial[WIDTH]) begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo_r[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvs_r    <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_r <= '0;
      ready_r  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          ready_r  <= 1'b0;
          result_r <= '0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state   <= S_ON;
              quo_r   <= op1_mag;
              dvs_r   <= op2_mag;
              rem_r   <= '0;
              cnt     <= '0;
              neg_quo <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
              neg_rem <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            end
          end
        end

        S_BYZERO: begin
          rem_r <= '0;
          quo_r <= '0;
          state <= bus.annul_i ? S_FREE : S_END;
        end

        S_ON: begin
          if (bus.annul_i) begin
            state   <= S_FREE;
            cnt     <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            dvs_r   <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
          end else if (cnt == CNT_W'(WIDTH)) begin
            state    <= S_END;
            ready_r  <= 1'b1;
            result_r <= {(neg_rem ? ~rem_r + WIDTH'(1) : rem_r),
                         (neg_quo ? ~quo_r + WIDTH'(1) : quo_r)};
          end else begin
            rem_r <= rem_nxt;
            quo_r <= quo_nxt;
            cnt   <= cnt + CNT_W'(1);
          end
        end

        S_END: begin
          // Divide-by-zero arrives with ready low; it rises here one edge later
          if (bus.annul_i || !bus.start_i) begin
            state    <= S_FREE;
            ready_r  <= 1'b0;
            result_r <= '0;
            cnt      <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            dvs_r    <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
          end else begin
            ready_r <= 1'b1;
          end
        end

        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Multi-cycle signed/unsigned 32-bit radix-2 restoring divider.
- Sits beside the EX stage: EX drives the operands and start, and raises its stall request to the pipeline controller while start_i=1 and ready_o=0.
- Produces {remainder, quotient} for the HI/LO-style writeback.
- Owns all iteration state. EX holds start_i and the operands stable until ready_o.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- start_i  input  1  request; level-held by EX until result consumed.
- annul_i  input  1  abort (flush/exception); overrides start_i.
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; registered.
- ready_o  output  1  result_o valid; registered.

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, cnt=0, ready_o=0, result_o=0, working registers=0.
- FSM states: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. On entry: latch |dividend| and |divisor|, where magnitudes are taken only if signed_div_i=1 and the MSB is set. Latch sign flags. Partial remainder=0, cnt=0.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: next edge -> END; quotient=0, remainder=0.
- ON:
  - annul_i=1 -> FREE, working state cleared; result_o and ready_o stay 0.
  - Otherwise, one iteration per cycle: shift {rem, quo} left 1; trial = rem - divisor; if trial is non-negative, rem=trial and quo LSB=1. cnt++.
  - When cnt reaches WIDTH -> END. Apply sign fixups:
    - quotient negated if signed_div_i=1 and the operand signs differ;
    - remainder negated if signed_div_i=1 and the dividend is negative.
  - Register result_o and assert ready_o.
- END:
  - ready_o=1 and result_o held while start_i=1.
  - start_i=0 -> FREE; ready_o=0 and result_o=0 on that edge.
  - annul_i=1 -> FREE, same clearing.
- Latency, with E0 = the edge that samples start_i=1 in FREE:
  - normal divide: ready_o=1 after edge E0+WIDTH+1 (33 cycles for WIDTH=32);
  - divide-by-zero: ready_o=1 after edge E0+2.
- Operand sampling: operands are sampled only at E0. Changes while in ON are ignored.
- Overflow (signed, 0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0, no trap.
- Back-to-back operations: after END->FREE, the next start can be sampled on the following edge. There is no direct END->ON path.
- Simultaneous start_i=1 and annul_i=1: annul wins in every state.
- Reset mid-operation: immediate return to reset values. No partial result is ever visible.
- Internal datapath: WIDTH+1-bit subtractor; the counter saturates at WIDTH; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-divide: drive rst=0 at cycle 10 of ON -> ready_o=0 and result_o=0 immediately (asynchronous). After rst=1, a fresh 100/7 completes with normal latency.
- Unsigned 100/7: signed_div_i=0, op1=100, op2=7, start held -> ready_o rises exactly 33 cycles after E0. result_o=0x00000002_0000000E, held until start_i=0, then 0 on the next edge.
- Signed -7/2: op1=0xFFFFFFF9, op2=2 -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3). Also signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divide by zero: op1=0x12345678, op2=0 -> ready_o after E0+2, result_o=0. A back-to-back unsigned 0xFFFFFFFF/1 started the cycle after release -> 0x00000000_FFFFFFFF.
- Annul: start 100/7, assert annul_i for one cycle at iteration 5 -> ready_o never rises, FSM in FREE. Restarting with start held -> correct result after a full 33 cycles.
- Signed overflow and random sweep:
  - 0x80000000/0xFFFFFFFF signed -> 0x00000000_80000000.
  - 10k random signed and unsigned pairs, checked against a reference model, with latency asserted constant.
